jt6295_rom_arb: RTL and testbench
=================================

JT6295_ROM_ARB -- requirements
Module: jt6295_rom_arb

Interface
REQ-001 Parameters (name, default, meaning): CH 4 number of requesting channels; AW 18 ROM byte-address width; DW 8 ROM data width.
REQ-002 clk input 1 system clock; all logic on rising edge.
REQ-003 rst input 1 synchronous, active-high reset.
REQ-004 cen input 1 clock enable; FSM advances only on cycles with cen=1.
REQ-005 cen_sr4 input 1 one-cycle strobe at 4x sample rate; marks a service window boundary.
REQ-006 req input CH per-channel read request, level, held until matching ack.
REQ-007 ch_addr input CH*AW per-channel byte address; channel n occupies bits [n*AW +: AW].
REQ-008 ack output CH per-channel one-cycle completion pulse, one-hot or zero.
REQ-009 ch_data output DW read data, valid on the ack cycle and held until the next ack.
REQ-010 rom_addr output AW ROM address.
REQ-011 rom_cs output 1 ROM chip select, high while a read is outstanding.
REQ-012 rom_data input DW ROM data.
REQ-013 rom_ok input 1 ROM data-valid indication for the current rom_addr.
REQ-014 ovf output CH sticky per-channel overrun flags.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, DONE; transitions evaluated only when cen=1.
REQ-016 IDLE: if any req bit is set, the first requester found round-robin, starting at index ptr+1 mod CH, is granted; the FSM latches grant index g and ch_addr[g] and moves to ISSUE; otherwise it stays in IDLE.
REQ-017 ISSUE: rom_addr is driven with the latched address and rom_cs is set to 1; the FSM moves to WAIT.
REQ-018 WAIT: rom_ok is ignored on the first WAIT cycle (stale-ok guard); on any later cen cycle with rom_ok=1, rom_data is captured into ch_data, rom_cs is cleared and the FSM moves to DONE.
REQ-019 DONE: ack[g] pulses for exactly one clk cycle if req[g] is still 1; ptr is set to g; the FSM returns to IDLE.
REQ-020 A request dropped before DONE still completes the ROM transaction, but its ack is suppressed and ch_data is not updated.
REQ-021 At most one ROM read is outstanding; rom_addr is stable while rom_cs=1.
REQ-022 Minimum latency, req rise to ack: 4 cen cycles (IDLE, ISSUE, WAIT guard, WAIT with rom_ok).
REQ-023 Round-robin pointer wraps from CH-1 to 0; with all req set, grants cycle 0,1,2,3,0,...
REQ-024 Each channel has a pending-at-strobe bit, set when cen_sr4=1 and req[n]=1 and n is not the current grant.
REQ-025 If that bit is already set at the next cen_sr4 while req[n] is still 1 and n is not granted, ovf[n] is set and stays set until reset.
REQ-026 ack[n] clears the pending-at-strobe bit for channel n.
REQ-027 cen_sr4 is sampled regardless of cen.
REQ-028 When cen_sr4 and DONE coincide for the same channel, the clear takes priority over the set.
REQ-029 When cen=0, all state, rom_cs and rom_addr hold; ack is 0.

Reset
REQ-030 When rst=1 at a clock edge: FSM goes to IDLE; ptr is set to CH-1 so the first grant goes to channel 0; rom_cs, ack, ovf and the pending bits are set to 0; rom_addr and ch_data are set to 0.
REQ-031 Reset during WAIT abandons the read without issuing an ack; a late rom_ok after reset is ignored.

Structure
REQ-032 The state encoding and the CH/AW/DW defaults are held in a shared package, jt6295_pkg.
REQ-033 The round-robin priority picker is one sub-module, jt6295_rr_pick: combinational, with inputs req and ptr and outputs grant index and valid.

Verification
REQ-034 Single request: req=4'b0010, ch_addr[1]=18'h00123, rom_ok high 2 cycles after cs, data 8'hA5 -> rom_addr=18'h00123, ack=4'b0010 once, ch_data=8'hA5.
REQ-035 Fairness: req=4'b1111 held for 8 transactions, cen=1 -> grant order 0,1,2,3,0,1,2,3.
REQ-036 Stale-ok guard: rom_ok tied to 1 -> ack exactly 4 cen cycles after req rise, never 3.
REQ-037 Dropped request: req[2] falls during WAIT -> rom_cs completes, no ack[2], ch_data unchanged.
REQ-038 Overrun: hold rom_ok=0 while req[3] stays high across two cen_sr4 strobes with channel 0 granted -> ovf=4'b1000, sticky until rst.
REQ-039 Reset mid-WAIT: assert rst for 1 cycle during WAIT -> rom_cs=0, no ack, next grant goes to channel 0.

Source files
------------

// File: rtl/jt6295_pkg.sv
// Shared parameters, FSM encoding and helpers for the jt6295 ROM arbiter.
package jt6295_pkg;

  localparam int JT_CH = 4;
  localparam int JT_AW = 18;
  localparam int JT_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_st_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jt6295_rr_pick.sv
// Round-robin picker: first set req bit scanning upward from ptr+1, wrapping at CH.
// Purely combinational; vld is low when no bit is set.
module jt6295_rr_pick
  import jt6295_pkg::*;
#(
  parameter int CH = JT_CH,
  parameter int PW = idx_w(JT_CH)
) (
  input  logic [CH-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          vld
);

  int j;

  always_comb begin
    idx = '0;
    vld = 1'b0;
    j   = 0;
    // ptr itself is scanned last, so the most recent grant has lowest priority.
    for (int i = 1; i <= CH; i++) begin
      j = (int'(ptr) + i) % CH;
      if (!vld && req[j]) begin
        vld = 1'b1;
        idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/jt6295_rom_arb.sv
// Shares one ROM port among CH channels; one read in flight, min 4 cen cycles req to ack.
// Channels wait by holding req; a channel skipped at two service windows is flagged in ovf.
module jt6295_rom_arb
  import jt6295_pkg::*;
#(
  parameter int CH = JT_CH,
  parameter int AW = JT_AW,
  parameter int DW = JT_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             cen_sr4,
  input  logic [CH-1:0]    req,
  input  logic [CH*AW-1:0] ch_addr,
  output logic [CH-1:0]    ack,
  output logic [DW-1:0]    ch_data,
  output logic [AW-1:0]    rom_addr,
  output logic             rom_cs,
  input  logic [DW-1:0]    rom_data,
  input  logic             rom_ok,
  output logic [CH-1:0]    ovf
);

  localparam int PW = idx_w(CH);

  arb_st_t       st;
  logic [PW-1:0] ptr;
  logic [PW-1:0] g;
  logic [AW-1:0] addr_l;
  logic          wait_first;
  logic [CH-1:0] pend;
  logic [PW-1:0] pick_idx;
  logic          pick_vld;
  logic [CH-1:0] g_hot;

  jt6295_rr_pick #(
    .CH (CH),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign g_hot = CH'(1) << g;

  // A requester that gave up before completion gets no ack.
  assign ack = (cen && st == ST_DONE && req[g]) ? g_hot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      ptr        <= PW'(CH - 1);
      g          <= '0;
      addr_l     <= '0;
      wait_first <= 1'b0;
      rom_addr   <= '0;
      rom_cs     <= 1'b0;
      ch_data    <= '0;
    end else if (cen) begin
      case (st)
        ST_IDLE: begin
          if (pick_vld) begin
            g      <= pick_idx;
            addr_l <= ch_addr[int'(pick_idx)*AW +: AW];
            st     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rom_addr   <= addr_l;
          rom_cs     <= 1'b1;
          wait_first <= 1'b1;
          st         <= ST_WAIT;
        end
        ST_WAIT: begin
          // rom_ok on the first WAIT cycle may still refer to the previous address.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (rom_ok) begin
            if (req[g]) ch_data <= rom_data;
            rom_cs <= 1'b0;
            st     <= ST_DONE;
          end
        end
        ST_DONE: begin
          ptr <= g;
          st  <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // Service-window tracking runs on every clk, independent of cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      ovf  <= '0;
    end else begin
      for (int n = 0; n < CH; n++) begin
        if (cen_sr4 && req[n] && !(st != ST_IDLE && g == PW'(n))) begin
          if (pend[n]) ovf[n] <= 1'b1;
          pend[n] <= 1'b1;
        end
        if (ack[n]) pend[n] <= 1'b0;
      end
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));

  a_addr_stable: assert property (@(posedge clk) disable iff (rst)
    (rom_cs && $past(rom_cs)) |-> (rom_addr == $past(rom_addr)));

endmodule

// File: tb/tb_jt6295_rom_arb.sv
module tb_jt6295_rom_arb;
  import jt6295_pkg::*;

  localparam int CH = JT_CH;
  localparam int AW = JT_AW;
  localparam int DW = JT_DW;

  logic             clk = 1'b0;
  logic             rst;
  logic             cen;
  logic             cen_sr4;
  logic [CH-1:0]    req;
  logic [CH*AW-1:0] ch_addr;
  logic [CH-1:0]    ack;
  logic [DW-1:0]    ch_data;
  logic [AW-1:0]    rom_addr;
  logic             rom_cs;
  logic [DW-1:0]    rom_data;
  logic             rom_ok;
  logic [CH-1:0]    ovf;

  jt6295_rom_arb #(.CH(CH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .cen_sr4  (cen_sr4),
    .req      (req),
    .ch_addr  (ch_addr),
    .ack      (ack),
    .ch_data  (ch_data),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          e;
  int            n_chk   = 0;
  int            n_err   = 0;
  int            ack_cnt = 0;
  logic [CH-1:0] last_ack = '0;
  bit            ok_tied = 1'b0;
  bit            ok_hold = 1'b0;
  bit            cen_rnd = 1'b0;
  int            cs_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h86;
  endfunction

  // ROM model and cen generator: rom_ok rises on the second cycle of rom_cs.
  initial begin
    cen      = 1'b1;
    rom_ok   = 1'b0;
    rom_data = '0;
    forever begin
      @(posedge clk);
      #1;
      cen = cen_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rom_cs === 1'b1) cs_cnt++;
      else cs_cnt = 0;
      rom_ok   = ok_tied || (rom_cs === 1'b1 && !ok_hold && cs_cnt >= 2);
      rom_data = rom_fn(rom_addr);
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (!cen) check("ack_when_cen_low", 32'(ack), 32'd0);
        if (ack != '0) begin
          ack_cnt++;
          last_ack = ack;
          if (sb_q.size() == 0) begin
            check("unexpected_ack", 32'(ack), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("ack_channel", 32'(ack), 32'(1) << e.ch);
            check("ch_data", 32'(ch_data), 32'(e.data));
          end
        end
        if (rom_cs && sb_q.size() > 0) check("rom_addr", 32'(rom_addr), 32'(sb_q[0].addr));
      end
    end
  end

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    ch_addr[ch*AW +: AW] = a;
  endtask

  task automatic expect_ack(input int ch);
    exp_t x;
    x.ch   = 2'(ch);
    x.addr = ch_addr[ch*AW +: AW];
    x.data = rom_fn(x.addr);
    sb_q.push_back(x);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n, input bit drop);
    int tgt;
    int t;
    for (int k = 0; k < n; k++) begin
      tgt = ack_cnt + 1;
      t   = 0;
      while (ack_cnt < tgt && t < 200) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (ack_cnt < tgt) begin
        check("ack_timeout", 32'(ack_cnt), 32'(tgt));
        return;
      end
      if (drop) req = req & ~last_ack;
    end
  endtask

  task automatic wait_cs();
    int t = 0;
    while (rom_cs !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (rom_cs !== 1'b1) check("cs_timeout", 32'(rom_cs), 32'd1);
  endtask

  task automatic strobe();
    @(posedge clk);
    #1 cen_sr4 = 1'b1;
    @(posedge clk);
    #1 cen_sr4 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cen_sr4 = 1'b0;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    int            lat;
    int            c0;
    int            t;
    logic [DW-1:0] d0;
    rst = 1'b1;
    req = '0;
    cen_sr4 = 1'b0;
    ch_addr = '0;
    cycles(3);
    rst = 1'b0;

    @(negedge clk);
    check("rst_rom_cs", 32'(rom_cs), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_ch_data", 32'(ch_data), 32'd0);

    // Overrun: ch0 stuck in WAIT while ch3 waits through two strobes.
    set_addr(0, 18'h00400);
    set_addr(3, 18'h03c5a);
    ok_hold = 1'b1;
    expect_ack(0);
    expect_ack(3);
    req = 4'b1001;
    wait_cs();
    strobe();
    cycles(3);
    check("ovf_one_strobe", 32'(ovf), 32'd0);
    strobe();
    check("ovf_two_strobes", 32'(ovf), 32'h8);
    ok_hold = 1'b0;
    wait_acks(2, 1'b1);
    cycles(4);
    check("ovf_sticky", 32'(ovf), 32'h8);
    do_reset();
    check("ovf_after_rst", 32'(ovf), 32'd0);

    // Fairness: all four held for eight transactions.
    for (int c = 0; c < CH; c++) set_addr(c, AW'(18'h10000 + c * 18'h00111));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CH; c++) expect_ack(c);
    req = 4'b1111;
    wait_acks(8, 1'b0);
    req = '0;
    cycles(6);
    check("fair_drained", 32'(sb_q.size()), 32'd0);

    // Single request on channel 1.
    set_addr(1, 18'h00123);
    expect_ack(1);
    c0 = ack_cnt;
    req = 4'b0010;
    wait_acks(1, 1'b1);
    check("single_data", 32'(ch_data), 32'hA5);
    cycles(8);
    check("single_ack_once", 32'(ack_cnt - c0), 32'd1);

    // Stale-ok guard: rom_ok tied high.
    ok_tied = 1'b1;
    set_addr(0, 18'h2aaaa);
    expect_ack(0);
    req = 4'b0001;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (ack == '0 && lat < 20);
    req = '0;
    check("ack_latency", 32'(lat), 32'd4);
    ok_tied = 1'b0;
    cycles(4);

    // Dropped request on channel 2 during WAIT.
    ok_hold = 1'b1;
    set_addr(2, 18'h01f00);
    d0 = ch_data;
    c0 = ack_cnt;
    req = 4'b0100;
    wait_cs();
    cycles(2);
    req = '0;
    ok_hold = 1'b0;
    t = 0;
    while (rom_cs !== 1'b0 && t < 50) begin
      cycles(1);
      t++;
    end
    check("drop_cs_done", 32'(rom_cs), 32'd0);
    cycles(6);
    check("drop_no_ack", 32'(ack_cnt), 32'(c0));
    check("drop_data_held", 32'(ch_data), 32'(d0));

    // Reset while waiting on channel 2, then ch0/ch3 compete.
    ok_hold = 1'b1;
    set_addr(2, 18'h00777);
    expect_ack(2);
    req = 4'b0100;
    wait_cs();
    cycles(2);
    rst = 1'b1;
    req = '0;
    cycles(1);
    rst = 1'b0;
    sb_q.delete();
    c0 = ack_cnt;
    check("midwait_rst_cs", 32'(rom_cs), 32'd0);
    check("midwait_rst_ack", 32'(ack), 32'd0);
    ok_hold = 1'b0;
    ok_tied = 1'b1;
    cycles(3);
    check("midwait_no_ack", 32'(ack_cnt), 32'(c0));
    ok_tied = 1'b0;
    set_addr(0, 18'h00abc);
    set_addr(3, 18'h00def);
    expect_ack(0);
    expect_ack(3);
    req = 4'b1001;
    wait_acks(2, 1'b1);
    cycles(4);

    // Random cen with single random requests.
    cen_rnd = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int ch;
      ch = $urandom_range(0, CH - 1);
      set_addr(ch, AW'($urandom));
      expect_ack(ch);
      req = CH'(1) << ch;
      wait_acks(1, 1'b1);
      cycles(3);
    end
    cen_rnd = 1'b0;

    cycles(6);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
